// File: rtl/fpu_pkg.sv
// Shared FPU writeback definitions.
// Holds the default result/tag widths and the {tag,data} writeback record used
// by the float-to-int converter and every FPU writeback buffer.
package fpu_pkg;

  localparam int FPU_DATA_W = 32;
  localparam int FPU_TAG_W  = 6;

  typedef struct packed {
    logic [FPU_TAG_W-1:0]  tag;
    logic [FPU_DATA_W-1:0] data;
  } fpu_wb_t;

  // Pointer width for a FIFO of the given depth; a depth of one still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO for FPU writeback records.
// Ports:
//   sys_clk, rstn      clock, synchronous active-low reset
//   push, push_data    write one entry (ignored when full unless popping the same cycle)
//   pop                remove the head (ignored when empty)
//   full, empty, count status, count is registered
//   head               current head entry, zero while empty
// Pointers wrap modulo DEPTH, so DEPTH does not have to be a power of two.
module fpu_sync_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fpu_wb_t,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output T                 head
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;
  T                 mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // A pop frees the slot in the same cycle, so a full FIFO can still take a push then.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head = empty ? T'('0) : mem[rd_ptr_q];

endmodule

// File: rtl/ftoi_wb_buffer.sv
// Float-to-int converter writeback buffer.
// Carries each issued op's destination tag through a delay line matched to the
// converter latency, pairs it with the converter result, buffers {tag,data} and
// drains it to the integer register-file writeback port over valid/ready.
// Ports:
//   sys_clk, rstn                    clock, synchronous active-low reset
//   issue_valid, issue_tag           op handed to the converter this cycle
//   issue_ready                      credit available (registered state only)
//   res_valid, res_data              converter output
//   wb_valid, wb_tag, wb_data        FIFO head
//   wb_ready                         writeback port accepts the head
//   occupancy                        entries held in the FIFO
//   err_orphan, err_missing          sticky pairing errors, cleared by reset only
module ftoi_wb_buffer
  import fpu_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  LAT    = 1,
  parameter int  TAG_W  = FPU_TAG_W,
  parameter int  DATA_W = FPU_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              issue_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic              err_orphan,
  output logic              err_missing
);

  localparam int SUM_W = $clog2(DEPTH + LAT + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic [LAT-1:0]   dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0] dl_tag_q [LAT];
  logic [TAG_W-1:0] dl_tag_d [LAT];
  logic             err_orphan_q, err_orphan_d;
  logic             err_missing_q, err_missing_d;

  logic             issue_fire;
  logic             tag_out_vld;
  logic [TAG_W-1:0] tag_out;
  logic [SUM_W-1:0] inflight;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  wb_t              fifo_in;
  wb_t              fifo_head;

  // Credit check sees only registered state, so wb_ready never reaches issue_ready.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SUM_W'(dl_vld_q[i]);
    end
  end

  assign issue_ready = (SUM_W'(occupancy) + inflight) < SUM_W'(DEPTH);
  assign issue_fire  = issue_valid & issue_ready;

  always_comb begin
    dl_vld_d    = dl_vld_q;
    dl_vld_d[0] = issue_fire;
    dl_tag_d[0] = issue_tag;
    for (int i = 1; i < LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  assign tag_out_vld = dl_vld_q[LAT-1];
  assign tag_out     = dl_tag_q[LAT-1];

  // A tag without a result simply falls off the delay line, which releases its credit.
  assign fifo_push    = tag_out_vld & res_valid;
  assign fifo_in.tag  = tag_out;
  assign fifo_in.data = res_data;
  assign fifo_pop     = wb_valid & wb_ready;
  assign fifo_drop    = fifo_push & fifo_full & ~fifo_pop;

  always_comb begin
    err_orphan_d  = err_orphan_q | (res_valid & ~tag_out_vld) | fifo_drop;
    err_missing_d = err_missing_q | (tag_out_vld & ~res_valid);
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      dl_vld_q      <= '0;
      err_orphan_q  <= 1'b0;
      err_missing_q <= 1'b0;
      for (int i = 0; i < LAT; i++) dl_tag_q[i] <= '0;
    end else begin
      dl_vld_q      <= dl_vld_d;
      err_orphan_q  <= err_orphan_d;
      err_missing_q <= err_missing_d;
      for (int i = 0; i < LAT; i++) dl_tag_q[i] <= dl_tag_d[i];
    end
  end

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_t)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy),
    .head      (fifo_head)
  );

  assign wb_valid    = ~fifo_empty;
  assign wb_tag      = fifo_head.tag;
  assign wb_data     = fifo_head.data;
  assign err_orphan  = err_orphan_q;
  assign err_missing = err_missing_q;

endmodule

// File: tb/tb_ftoi_wb_buffer.sv
module tb_ftoi_wb_buffer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic        sys_clk;
  logic        rstn;
  logic        issue_valid;
  logic [5:0]  issue_tag;
  logic        issue_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [2:0]  occupancy;
  logic        err_orphan;
  logic        err_missing;

  ftoi_wb_buffer #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(6), .DATA_W(32)) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .occupancy   (occupancy),
    .err_orphan  (err_orphan),
    .err_missing (err_missing)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: ops in flight with their issue cycle, and the ordered writeback queue.
  typedef struct { logic [5:0] tag; int cyc; } inf_t;
  typedef struct { logic [5:0] tag; logic [31:0] data; } ent_t;
  inf_t inf_q[$];
  ent_t fifo_q[$];
  bit   m_orph, m_miss;
  int   cyc_now;
  int   n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [5:0]  e_tag;
    logic [31:0] e_data;
    e_tag  = '0;
    e_data = '0;
    if (fifo_q.size() > 0) begin
      e_tag  = fifo_q[0].tag;
      e_data = fifo_q[0].data;
    end
    chk("wb_valid", 64'(wb_valid), 64'(fifo_q.size() > 0));
    chk("wb_tag", 64'(wb_tag), 64'(e_tag));
    chk("wb_data", 64'(wb_data), 64'(e_data));
    chk("occupancy", 64'(occupancy), 64'(fifo_q.size()));
    chk("issue_ready", 64'(issue_ready), 64'((fifo_q.size() + inf_q.size()) < DEPTH));
    chk("err_orphan", 64'(err_orphan), 64'(m_orph));
    chk("err_missing", 64'(err_missing), 64'(m_miss));
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      rstn        = 1'b0;
      issue_valid = 1'b1;
      issue_tag   = 6'h3F;
      res_valid   = 1'b0;
      res_data    = '0;
      wb_ready    = 1'b1;
      @(posedge sys_clk);
      fifo_q.delete();
      inf_q.delete();
      m_orph = 1'b0;
      m_miss = 1'b0;
      cyc_now++;
      @(negedge sys_clk);
      check_all();
    end
  endtask

  // One cycle: drive inputs, emulate the converter, advance the model, check outputs.
  task automatic step(input bit iv, input logic [5:0] tg, input bit wr,
                      input bit sup, input bit inj, input logic [31:0] dat);
    bit   due, rv, rdy, acc, pop, push;
    ent_t e;
    rstn = 1'b1;
    due  = (inf_q.size() > 0) && (inf_q[0].cyc == cyc_now - LAT);
    rv   = (due && !sup) || inj;
    rdy  = (fifo_q.size() + inf_q.size()) < DEPTH;
    acc  = iv && rdy;
    issue_valid = iv;
    issue_tag   = tg;
    wb_ready    = wr;
    res_valid   = rv;
    res_data    = rv ? dat : 32'h0;
    e.tag  = due ? inf_q[0].tag : 6'h0;
    e.data = dat;
    @(posedge sys_clk);
    pop  = (fifo_q.size() > 0) && wr;
    push = due && rv;
    if (due && !rv) m_miss = 1'b1;
    if (!due && rv) m_orph = 1'b1;
    if (push && fifo_q.size() == DEPTH && !pop) begin
      push   = 1'b0;
      m_orph = 1'b1;
    end
    if (due) void'(inf_q.pop_front());
    if (pop) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(e);
    if (acc) begin
      inf_t f;
      f.tag = tg;
      f.cyc = cyc_now;
      inf_q.push_back(f);
    end
    cyc_now++;
    @(negedge sys_clk);
    check_all();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc_now = 0;
    m_orph = 0; m_miss = 0;
    rstn = 0; issue_valid = 0; issue_tag = 0; res_valid = 0; res_data = 0; wb_ready = 0;
    @(negedge sys_clk);

    do_reset(2);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);

    // single op, tag 5
    step(1, 6'd5, 0, 0, 0, 32'h0);
    step(0, 6'd0, 0, 0, 0, 32'h0000_002A);
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_tag", 64'(wb_tag), 64'd5);
    chk("t1_wb_data", 64'(wb_data), 64'h2A);
    chk("t1_occ", 64'(occupancy), 64'd1);
    step(0, 6'd0, 1, 0, 0, 32'h0);
    chk("t1_occ_after_pop", 64'(occupancy), 64'd0);

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      step(1, 6'(i), 1, 0, 0, $urandom());
      chk("t2_ready", 64'(issue_ready), 64'd1);
    end
    for (int i = 0; i < 3; i++) step(0, 6'd0, 1, 0, 0, $urandom());
    chk("t2_no_err", 64'({err_orphan, err_missing}), 64'd0);

    // backpressure fills exactly DEPTH entries
    for (int i = 0; i < 6; i++) step(1, 6'(16 + i), 0, 0, 0, $urandom());
    chk("t3_occ_full", 64'(occupancy), 64'd4);
    chk("t3_ready_low", 64'(issue_ready), 64'd0);
    chk("t3_head", 64'(wb_tag), 64'd16);
    for (int i = 0; i < 6; i++) step(0, 6'd0, 1, 0, 0, $urandom());
    chk("t3_drained", 64'(occupancy), 64'd0);
    chk("t3_ready_back", 64'(issue_ready), 64'd1);

    // simultaneous push and pop at occupancy 3
    step(1, 6'd30, 0, 0, 0, $urandom());
    step(1, 6'd31, 0, 0, 0, $urandom());
    step(1, 6'd32, 0, 0, 0, $urandom());
    step(1, 6'd33, 0, 0, 0, $urandom());
    chk("t4_occ3", 64'(occupancy), 64'd3);
    step(0, 6'd0, 1, 0, 0, $urandom());
    chk("t4_occ_hold", 64'(occupancy), 64'd3);
    chk("t4_head", 64'(wb_tag), 64'd31);
    for (int i = 0; i < 4; i++) step(0, 6'd0, 1, 0, 0, $urandom());

    // orphan result, then missing result
    step(0, 6'd0, 1, 0, 1, $urandom());
    chk("t5_orphan", 64'(err_orphan), 64'd1);
    chk("t5_no_push", 64'(occupancy), 64'd0);
    step(1, 6'd9, 1, 0, 0, $urandom());
    step(0, 6'd0, 1, 1, 0, $urandom());
    chk("t5_missing", 64'(err_missing), 64'd1);
    chk("t5_credit", 64'(issue_ready), 64'd1);
    chk("t5_occ", 64'(occupancy), 64'd0);

    // reset with entries buffered and one in flight
    for (int i = 0; i < 4; i++) step(1, 6'(40 + i), 0, 0, 0, $urandom());
    chk("t6_pre_occ", 64'(occupancy), 64'd3);
    do_reset(1);
    chk("t6_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_ready", 64'(issue_ready), 64'd1);
    chk("t6_errs", 64'({err_orphan, err_missing}), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 6'd0, 1, 0, 0, $urandom());
    chk("t6_no_stale", 64'(wb_valid), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 6'($urandom()), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom());
    end
    for (int i = 0; i < 8; i++) step(0, 6'd0, 1, 0, 0, $urandom());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
